tdc_channel_enable_ctrl: RTL

Parametrised channel-enable controller for the TDC front end of the Sigma Delta DAQ. It takes the channel mask written by the register bank and applies it to up to 32 TDC channels using break-before-make sequencing. Channels being disabled are allowed to finish any measurement in progress (with a timeout), and a guard interval separates disables from enables. The applied mask is reported back to the register bank through a request/acknowledge handshake, together with sticky configuration and timeout flags.

---
 rtl/tdc_channel_enable_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tdc_channel_enable_ctrl.sv
// tdc_channel_enable_ctrl
// Applies the register-bank channel mask to the TDC channels with
// break-before-make sequencing:
//   IDLE   -> wait for a request (queued request first, then a live pulse)
//   DRAIN  -> wait for channels being dropped to go idle (bounded by a timeout)
//   GUARD  -> disables applied, wait a fixed guard interval before enabling
//   NOTIFY -> full mask applied, hold the read request until acknowledged
// Requests arriving outside IDLE go into a one-entry queue (last write wins).
//
// Register-bank handshake: read_active_channel is a level request. It rises
// with the applied mask and flags already stable, and stays high until
// read_ack is sampled high in NOTIFY. read_ack seen in any other state has
// no effect.
module tdc_channel_enable_ctrl #(
    parameter int CHANNEL_COUNT = 2,
    parameter int REG_WIDTH     = 32,
    parameter int GUARD_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REG_WIDTH-1:0]     activate_channels,
    input  logic                     channel_changed,
    input  logic                     read_ack,
    input  logic [CHANNEL_COUNT-1:0] busy,
    output logic [CHANNEL_COUNT-1:0] enable_channels,
    output logic                     read_active_channel,
    output logic [REG_WIDTH-1:0]     active_mask,
    output logic                     cfg_error,
    output logic                     drain_timeout,
    output logic                     update_pending,
    output logic [1:0]               dbg_state
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2,
        ST_NOTIFY = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [CHANNEL_COUNT-1:0] r_enable;
    logic [CHANNEL_COUNT-1:0] r_pending;
    logic [CHANNEL_COUNT-1:0] r_q_mask;
    logic                     r_q_valid;
    logic                     r_rac;
    logic                     r_cfg_error;
    logic                     r_drain_timeout;
    logic [DW-1:0]            r_drain_cnt;
    logic [GW-1:0]            r_guard_cnt;

    logic                     w_upper_err;
    logic [CHANNEL_COUNT-1:0] w_req_mask;
    logic                     w_in_idle;
    logic                     w_capture;
    logic                     w_req_same;
    logic [CHANNEL_COUNT-1:0] w_drop;
    logic                     w_drop_busy;
    logic                     w_drain_expired;
    logic                     w_drain_done;
    logic                     w_guard_done;

    logic                     w_inc_drain;
    logic                     w_apply_drop;
    logic                     w_set_timeout;
    logic                     w_inc_guard;
    logic                     w_apply_full;
    logic                     w_set_rac;
    logic                     w_done_ack;
    logic                     w_q_store;
    logic                     w_q_take;
    logic                     w_cfg_set;

    // Bits above the implemented channel count are a configuration error.
    generate
        if (CHANNEL_COUNT < REG_WIDTH) begin : g_upper
            assign w_upper_err = |activate_channels[REG_WIDTH-1:CHANNEL_COUNT];
        end else begin : g_no_upper
            assign w_upper_err = 1'b0;
        end
    endgenerate

    // The queued request wins over a live pulse when both are present in IDLE.
    assign w_req_mask      = r_q_valid ? r_q_mask : activate_channels[CHANNEL_COUNT-1:0];
    assign w_in_idle       = (r_state == ST_IDLE);
    assign w_capture       = w_in_idle && (r_q_valid || channel_changed);
    assign w_req_same      = (w_req_mask == r_enable);
    // Channels that are currently on but not wanted; only their busy bits count.
    assign w_drop          = r_enable & ~r_pending;
    assign w_drop_busy     = |(busy & w_drop);
    assign w_drain_expired = (r_drain_cnt == DRAIN_LAST);
    assign w_drain_done    = !w_drop_busy || w_drain_expired;
    assign w_guard_done    = (r_guard_cnt == GUARD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_next_state = w_req_same ? ST_NOTIFY : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next_state = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (w_guard_done) begin
                    w_next_state = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                if (read_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state control strobes that drive the registered outputs and counters.
    always_comb begin
        w_inc_drain   = 1'b0;
        w_apply_drop  = 1'b0;
        w_set_timeout = 1'b0;
        w_inc_guard   = 1'b0;
        w_apply_full  = 1'b0;
        w_done_ack    = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                w_apply_drop  = w_drain_done;
                w_inc_drain   = !w_drain_done;
                w_set_timeout = w_drop_busy && w_drain_expired;
            end
            ST_GUARD: begin
                w_apply_full = w_guard_done;
                w_inc_guard  = !w_guard_done;
            end
            ST_NOTIFY: begin
                w_done_ack = read_ack;
            end
            default: ;
        endcase
        w_set_rac = (w_capture && w_req_same) || w_apply_full;
        // A pulse that cannot be taken directly is queued; this includes the
        // IDLE cycle in which the queue itself is being drained.
        w_q_store = channel_changed && (!w_in_idle || r_q_valid);
        w_q_take  = w_in_idle && r_q_valid;
        w_cfg_set = channel_changed && w_upper_err;
    end

    // Target mask latched on capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else if (w_capture) begin
            r_pending <= w_req_mask;
        end
    end

    // Channel enables: disables first (DRAIN exit), full mask after the guard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= '0;
        end else if (w_apply_drop) begin
            r_enable <= r_enable & r_pending;
        end else if (w_apply_full) begin
            r_enable <= r_pending;
        end
    end

    // One-entry request queue, newest pulse overwrites.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q_valid <= 1'b0;
            r_q_mask  <= '0;
        end else if (w_q_store) begin
            r_q_valid <= 1'b1;
            r_q_mask  <= activate_channels[CHANNEL_COUNT-1:0];
        end else if (w_q_take) begin
            r_q_valid <= 1'b0;
        end
    end

    // Read request to the register bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rac <= 1'b0;
        end else if (w_set_rac) begin
            r_rac <= 1'b1;
        end else if (w_done_ack) begin
            r_rac <= 1'b0;
        end
    end

    // Sticky flags; a new error in the ack cycle survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_error     <= 1'b0;
            r_drain_timeout <= 1'b0;
        end else begin
            if (w_cfg_set) begin
                r_cfg_error <= 1'b1;
            end else if (w_done_ack) begin
                r_cfg_error <= 1'b0;
            end
            if (w_set_timeout) begin
                r_drain_timeout <= 1'b1;
            end else if (w_done_ack) begin
                r_drain_timeout <= 1'b0;
            end
        end
    end

    // Drain wait counter, restarted on every capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drain_cnt <= '0;
        end else if (w_capture) begin
            r_drain_cnt <= '0;
        end else if (w_inc_drain) begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
        end
    end

    // Guard interval counter, restarted when the disables are applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_guard_cnt <= '0;
        end else if (w_apply_drop) begin
            r_guard_cnt <= '0;
        end else if (w_inc_guard) begin
            r_guard_cnt <= r_guard_cnt + GW'(1);
        end
    end

    // Zero-extend the applied mask for the register bank.
    always_comb begin
        active_mask                      = '0;
        active_mask[CHANNEL_COUNT-1:0]   = r_enable;
    end

    assign enable_channels     = r_enable;
    assign read_active_channel = r_rac;
    assign cfg_error           = r_cfg_error;
    assign drain_timeout       = r_drain_timeout;
    assign update_pending      = r_q_valid;
    assign dbg_state           = r_state;

endmodule
